// File: rtl/multi_channel_timer.sv
// NUM_CH independent prescaled down-counters behind one 16-bit Avalon-MM slave.
// Each channel has period, snapshot, timeout flag and its own interrupt line.
module multi_channel_timer #(
    parameter int          NUM_CH         = 4,
    parameter int          CNT_W          = 32,
    parameter int          PRESCALE_W     = 8,
    parameter logic [31:0] DEFAULT_PERIOD = 32'hB2D05DFF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [$clog2(NUM_CH)+2:0]   address,
    input  logic                        chipselect,
    input  logic                        write_n,
    input  logic [15:0]                 writedata,
    output logic [15:0]                 readdata,
    output logic [NUM_CH-1:0]           irq_ch,
    output logic                        irq
);

    localparam int AW = $clog2(NUM_CH) + 3;
    localparam logic [CNT_W-1:0] RST_PERIOD = DEFAULT_PERIOD[CNT_W-1:0];

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;
    localparam logic [2:0] REG_PRESCALE = 3'd6;

    logic          wr;
    logic [2:0]    reg_sel;
    logic [AW-1:0] ch_sel;
    logic [15:0]   ch_rdata [NUM_CH];
    logic [15:0]   rd_mux;

    assign wr      = chipselect & ~write_n;
    assign reg_sel = address[2:0];
    assign ch_sel  = address >> 3;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic                  sel;
        logic                  tick;
        logic                  timeout;
        logic                  to;
        logic                  run;
        logic                  ito;
        logic                  cont;
        logic [CNT_W-1:0]      counter;
        logic [CNT_W-1:0]      period;
        logic [CNT_W-1:0]      snap;
        logic [PRESCALE_W-1:0] prescale;
        logic [PRESCALE_W-1:0] pcnt;
        logic [31:0]           period_z;
        logic [31:0]           snap_z;
        logic [31:0]           period_wr;

        assign sel      = wr && (ch_sel == AW'(i));
        assign tick     = run && (pcnt == '0);
        assign timeout  = tick && (counter == '0);
        assign period_z = 32'(period);
        assign snap_z   = 32'(snap);

        // Half-word period update applied on a zero-extended copy so bits above CNT_W drop out.
        always_comb begin
            period_wr = period_z;
            if (reg_sel == REG_PERIOD_L)
                period_wr[15:0] = writedata;
            else
                period_wr[31:16] = writedata;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                to       <= 1'b0;
                run      <= 1'b0;
                ito      <= 1'b0;
                cont     <= 1'b0;
                prescale <= '0;
                pcnt     <= '0;
                snap     <= '0;
                period   <= RST_PERIOD;
                counter  <= RST_PERIOD;
            end else begin
                if (tick) begin
                    pcnt <= prescale;
                    if (counter == '0) begin
                        counter <= period;
                        if (!cont)
                            run <= 1'b0;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end else if (run) begin
                    pcnt <= pcnt - PRESCALE_W'(1);
                end

                // A timeout in the same cycle as a STATUS write must not be lost.
                to <= timeout | (to & ~(sel && (reg_sel == REG_STATUS)));

                // Register writes are applied last so they override the counting path.
                if (sel) begin
                    case (reg_sel)
                        REG_CONTROL: begin
                            ito  <= writedata[0];
                            cont <= writedata[1];
                            if (writedata[2]) begin
                                run  <= 1'b1;
                                pcnt <= prescale;
                            end else if (writedata[3]) begin
                                run <= 1'b0;
                            end
                        end
                        REG_PERIOD_L, REG_PERIOD_H: begin
                            period  <= period_wr[CNT_W-1:0];
                            counter <= period_wr[CNT_W-1:0];
                            pcnt    <= prescale;
                            run     <= 1'b0;
                        end
                        REG_SNAP_L, REG_SNAP_H: snap <= counter;
                        REG_PRESCALE:           prescale <= writedata[PRESCALE_W-1:0];
                        default: ;
                    endcase
                end
            end
        end

        always_comb begin
            case (reg_sel)
                REG_STATUS:   ch_rdata[i] = {14'd0, run, to};
                REG_CONTROL:  ch_rdata[i] = {14'd0, cont, ito};
                REG_PERIOD_L: ch_rdata[i] = period_z[15:0];
                REG_PERIOD_H: ch_rdata[i] = period_z[31:16];
                REG_SNAP_L:   ch_rdata[i] = snap_z[15:0];
                REG_SNAP_H:   ch_rdata[i] = snap_z[31:16];
                REG_PRESCALE: ch_rdata[i] = 16'(prescale);
                default:      ch_rdata[i] = 16'd0;
            endcase
        end

        assign irq_ch[i] = to & ito;
    end

    // Channel indices with no timer behind them read as zero.
    always_comb begin
        rd_mux = 16'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel == AW'(i))
                rd_mux = ch_rdata[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            readdata <= 16'd0;
        else if (chipselect)
            readdata <= rd_mux;
    end

    assign irq = |irq_ch;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Self-checking bench for multi_channel_timer: reset table, per-channel timing
// sequences, simultaneous-event corners, and a multi-channel schedule model.
module tb_multi_channel_timer;

    localparam int NUM_CH = 4;
    localparam int AW     = $clog2(NUM_CH) + 3;

    localparam int R_STATUS = 0, R_CONTROL = 1, R_PL = 2, R_PH = 3;
    localparam int R_SL = 4, R_SH = 5, R_PRE = 6, R_RSV = 7;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [AW-1:0]     address = '0;
    logic [15:0]       writedata = '0;
    logic [15:0]       readdata;
    logic [NUM_CH-1:0] irq_ch;
    logic              irq;

    multi_channel_timer dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq_ch     (irq_ch),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        int          ch;
        int          rg;
        logic [15:0] exp;
        string       name;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input int ch, input int rg, input logic [15:0] d);
        address    = AW'(ch * 8 + rg);
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input int ch, input int rg, input logic [15:0] exp, input string name);
        sb_t e;
        address    = AW'(ch * 8 + rg);
        chipselect = 1'b1;
        write_n    = 1'b1;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: scoreboard empty, got %h", name, readdata);
        end else begin
            e = sb_q.pop_front();
            check(e.name, 32'(readdata), 32'(e.exp));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          per[NUM_CH];
        int          start[NUM_CH];
        logic [3:0]  exp_irq;

        tbl[0] = '{0, R_PL,      16'h5DFF, "rst_ch0_period_l"};
        tbl[1] = '{0, R_PH,      16'hB2D0, "rst_ch0_period_h"};
        tbl[2] = '{0, R_STATUS,  16'h0000, "rst_ch0_status"};
        tbl[3] = '{0, R_CONTROL, 16'h0000, "rst_ch0_control"};
        tbl[4] = '{0, R_SL,      16'h0000, "rst_ch0_snap_l"};
        tbl[5] = '{0, R_SH,      16'h0000, "rst_ch0_snap_h"};
        tbl[6] = '{0, R_PRE,     16'h0000, "rst_ch0_prescale"};
        tbl[7] = '{0, R_RSV,     16'h0000, "rst_ch0_reserved"};
        tbl[8] = '{3, R_PH,      16'hB2D0, "rst_ch3_period_h"};
        tbl[9] = '{3, R_STATUS,  16'h0000, "rst_ch3_status"};

        step(3);
        reset = 1'b0;
        check("rst_readdata", 32'(readdata), 32'h0);
        check("rst_irq_ch", 32'(irq_ch), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        for (int i = 0; i < 10; i++)
            rd(tbl[i].ch, tbl[i].rg, tbl[i].exp, tbl[i].name);

        // ch1 continuous, period 9, prescale 0: timeout every 10 cycles
        wr(1, R_PL, 16'd9);
        wr(1, R_PH, 16'd0);
        wr(1, R_PRE, 16'd0);
        wr(1, R_CONTROL, 16'h0007);
        step(9);
        check("ch1_before_to", 32'(irq_ch), 32'h0);
        step(1);
        check("ch1_to_irq_ch", 32'(irq_ch), 32'h2);
        check("ch1_to_irq", 32'(irq), 32'h1);
        wr(1, R_SL, 16'd0);
        rd(1, R_SL, 16'd9, "ch1_reload_snap");
        rd(1, R_STATUS, 16'd3, "ch1_status_to_run");
        wr(1, R_STATUS, 16'd0);
        rd(1, R_STATUS, 16'd2, "ch1_status_cleared");
        step(4);
        check("ch1_before_to2", 32'(irq_ch), 32'h0);
        step(1);
        check("ch1_to2_irq_ch", 32'(irq_ch), 32'h2);
        wr(1, R_CONTROL, 16'h0008);
        wr(1, R_STATUS, 16'd0);
        check("ch1_stopped_irq", 32'(irq_ch), 32'h0);

        // ch2 one-shot, period 3, prescale 4: timeout after 20 cycles
        wr(2, R_PL, 16'd3);
        wr(2, R_PH, 16'd0);
        wr(2, R_PRE, 16'd4);
        wr(2, R_CONTROL, 16'h0005);
        step(19);
        check("ch2_before_to", 32'(irq_ch), 32'h0);
        step(1);
        check("ch2_to_irq_ch", 32'(irq_ch), 32'h4);
        rd(2, R_STATUS, 16'd1, "ch2_status_oneshot");
        wr(2, R_SL, 16'd0);
        rd(2, R_SL, 16'd3, "ch2_reload_snap");
        wr(2, R_STATUS, 16'd0);
        step(30);
        rd(2, R_STATUS, 16'd0, "ch2_no_more_to");
        check("ch2_idle_irq", 32'(irq_ch), 32'h0);
        wr(2, R_CONTROL, 16'd0);
        wr(2, R_PRE, 16'd0);

        // ch0 snapshot while running, then period write forces reload and stop
        wr(0, R_PH, 16'd0);
        wr(0, R_PL, 16'd50);
        wr(0, R_PRE, 16'd0);
        wr(0, R_CONTROL, 16'h0006);
        step(4);
        wr(0, R_SL, 16'd0);
        rd(0, R_SL, 16'd46, "ch0_snap_l_running");
        rd(0, R_SH, 16'd0, "ch0_snap_h_running");
        wr(0, R_PL, 16'd100);
        rd(0, R_STATUS, 16'd0, "ch0_period_wr_stops");
        wr(0, R_SH, 16'd0);
        rd(0, R_SL, 16'd100, "ch0_snap_after_period");
        rd(0, R_PL, 16'd100, "ch0_period_l_100");

        // ch3: STATUS write on the timeout cycle, START+STOP, ITO masking
        wr(3, R_PL, 16'd2);
        wr(3, R_PH, 16'd0);
        wr(3, R_PRE, 16'd0);
        wr(3, R_CONTROL, 16'h0006);
        step(2);
        wr(3, R_STATUS, 16'd0);
        rd(3, R_STATUS, 16'd3, "ch3_to_beats_clear");
        check("ch3_ito_off_irq", 32'(irq_ch), 32'h0);
        wr(3, R_CONTROL, 16'h0008);
        wr(3, R_CONTROL, 16'h000C);
        rd(3, R_STATUS, 16'd3, "ch3_start_wins");
        rd(3, R_STATUS, 16'd1, "ch3_oneshot_stop");
        wr(3, R_CONTROL, 16'h0001);
        check("ch3_ito_on_irq_ch", 32'(irq_ch), 32'h8);
        check("ch3_ito_on_irq", 32'(irq), 32'h1);
        wr(3, R_CONTROL, 16'h0000);
        check("ch3_ito_masked", 32'(irq_ch), 32'h0);
        rd(3, R_STATUS, 16'd1, "ch3_to_kept");
        wr(3, R_STATUS, 16'd0);

        // all channels running on independent schedules
        per = '{5, 7, 11, 13};
        for (int i = 0; i < NUM_CH; i++) begin
            wr(i, R_PH, 16'd0);
            wr(i, R_PL, 16'(per[i]));
            wr(i, R_PRE, 16'd0);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            wr(i, R_CONTROL, 16'h0007);
            start[i] = cyc;
        end
        for (int k = 0; k < 22; k++) begin
            exp_irq = '0;
            for (int i = 0; i < NUM_CH; i++)
                if (cyc - start[i] >= per[i] + 1)
                    exp_irq[i] = 1'b1;
            check($sformatf("multi_irq_ch_k%0d", k), 32'(irq_ch), 32'(exp_irq));
            check($sformatf("multi_irq_k%0d", k), 32'(irq), 32'(|exp_irq));
            step(1);
        end

        // reset mid-run
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        check("midrst_irq_ch", 32'(irq_ch), 32'h0);
        check("midrst_irq", 32'(irq), 32'h0);
        check("midrst_readdata", 32'(readdata), 32'h0);
        step(1);
        check("midrst_irq_next", 32'(irq), 32'h0);
        rd(2, R_PL, 16'h5DFF, "midrst_ch2_period_l");
        rd(1, R_STATUS, 16'd0, "midrst_ch1_status");
        rd(3, R_CONTROL, 16'd0, "midrst_ch3_control");
        rd(0, R_SL, 16'd0, "midrst_ch0_snap_l");
        step(20);
        check("midrst_idle_irq", 32'(irq), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
